// File: rtl/div_restore_pkg.sv
// rtl/div_restore_pkg.sv - shared state encoding and constants for the restoring divider
package div_restore_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  // Replicated across WIDTH to form the all-ones divide-by-zero quotient.
  localparam logic DIV_ZERO_Q = 1'b1;

  function automatic int cnt_width(input int width, input int frac_bits);
    return $clog2(width + frac_bits + 1);
  endfunction
endpackage

// File: rtl/div_sub_step.sv
// rtl/div_sub_step.sv - WIDTH+1-bit trial subtract (a + ~b + 1) with no-borrow flag
module div_sub_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   diff,
  output logic             no_borrow
);
  logic [WIDTH:0]   b_inv;
  logic [WIDTH+1:0] sum;

  // The carry out of the two's-complement add is set exactly when a >= b.
  assign b_inv     = ~{1'b0, b};
  assign sum       = {1'b0, a} + {1'b0, b_inv} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign diff      = sum[WIDTH:0];
  assign no_borrow = sum[WIDTH+1];
endmodule

// File: rtl/div_restore.sv
// rtl/div_restore.sv - iterative unsigned restoring divider, integer or 16.16 fractional
module div_restore
  import div_restore_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic             start,
  input  logic             frac,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);
  localparam int NW = WIDTH + FRAC;
  localparam int CW = cnt_width(WIDTH, FRAC);

  state_t           state;
  logic [WIDTH:0]   r;
  logic [NW-1:0]    n;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;
  logic             no_borrow;

  assign r_shift = {r[WIDTH-1:0], n[NW-1]};

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .a         (r_shift),
    .b         (d),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div0      <= 1'b0;
      r         <= '0;
      n         <= '0;
      d         <= '0;
      q         <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // The numerator is always left-aligned; frac mode only runs FRAC extra steps.
            n   <= {dividend, {FRAC{1'b0}}};
            d   <= divisor;
            cnt <= frac ? CW'(NW) : CW'(WIDTH);
            if (divisor == '0) begin
              q     <= {WIDTH{DIV_ZERO_Q}};
              r     <= {1'b0, dividend};
              div0  <= 1'b1;
              state <= S_FIN;
            end else begin
              q     <= '0;
              r     <= '0;
              busy  <= 1'b1;
              div0  <= 1'b0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r   <= no_borrow ? diff : r_shift;
          n   <= {n[NW-2:0], 1'b0};
          q   <= {q[WIDTH-2:0], no_borrow};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_FIN;
        end
        S_FIN: begin
          quotient  <= q;
          remainder <= r[WIDTH-1:0];
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_restore.sv
// tb/tb_div_restore.sv - directed self-checking bench for div_restore
module tb_div_restore;
  logic        sys_clk = 1'b0;
  logic        resetl;
  logic        start;
  logic        frac;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div0;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  div_restore #(.WIDTH(32), .FRAC(16)) dut (
    .sys_clk   (sys_clk),
    .resetl    (resetl),
    .start     (start),
    .frac      (frac),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a start pulse, then wait (bounded) for done; lat counts edges from acceptance.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic f,
                        output int lat, output bit busy_seen);
    dividend = a;
    divisor  = b;
    frac     = f;
    start    = 1'b1;
    @(posedge sys_clk); #1;
    start     = 1'b0;
    lat       = 0;
    busy_seen = busy;
    while (!done && lat < 200) begin
      @(posedge sys_clk); #1;
      lat++;
      if (busy) busy_seen = 1'b1;
    end
  endtask

  initial begin
    int  lat;
    bit  bsy;
    bit  done_seen;

    resetl = 1'b0; start = 1'b0; frac = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_q", 64'(quotient), 64'd0);
    chk("rst_r", 64'(remainder), 64'd0);
    chk("rst_div0", 64'(div0), 64'd0);
    resetl = 1'b1;
    @(posedge sys_clk); #1;

    run_op(32'd100, 32'd7, 1'b0, lat, bsy);
    chk("int_lat", 64'(lat), 64'd33);
    chk("int_q", 64'(quotient), 64'd14);
    chk("int_r", 64'(remainder), 64'd2);
    chk("int_div0", 64'(div0), 64'd0);
    chk("int_busy_seen", 64'(bsy), 64'd1);
    @(posedge sys_clk); #1;
    chk("int_done_pulse", 64'(done), 64'd0);

    run_op(32'd1, 32'd3, 1'b1, lat, bsy);
    chk("frac_lat", 64'(lat), 64'd49);
    chk("frac_q", 64'(quotient), 64'h0000_5555);
    chk("frac_r", 64'(remainder), 64'd1);
    @(posedge sys_clk); #1;

    run_op(32'h1234_5678, 32'd0, 1'b0, lat, bsy);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_q", 64'(quotient), 64'hFFFF_FFFF);
    chk("dz_r", 64'(remainder), 64'h1234_5678);
    chk("dz_div0", 64'(div0), 64'd1);
    chk("dz_busy_never", 64'(bsy), 64'd0);
    @(posedge sys_clk); #1;

    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat, bsy);
    chk("max_q", 64'(quotient), 64'hFFFF_FFFF);
    chk("max_r", 64'(remainder), 64'd0);
    chk("max_div0", 64'(div0), 64'd0);
    @(posedge sys_clk); #1;

    run_op(32'd5, 32'hFFFF_FFFF, 1'b0, lat, bsy);
    chk("big_div_q", 64'(quotient), 64'd0);
    chk("big_div_r", 64'(remainder), 64'd5);
    @(posedge sys_clk); #1;

    // Second start while busy must be ignored.
    dividend = 32'd100; divisor = 32'd7; frac = 1'b0; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 200) begin
      if (lat == 10) begin
        dividend = 32'd9; divisor = 32'd2; start = 1'b1;
      end
      @(posedge sys_clk); #1;
      start = 1'b0;
      lat++;
    end
    chk("hs_lat", 64'(lat), 64'd33);
    chk("hs_q", 64'(quotient), 64'd14);
    chk("hs_r", 64'(remainder), 64'd2);
    // Start in the cycle right after done is accepted.
    run_op(32'd9, 32'd2, 1'b0, lat, bsy);
    chk("hs2_lat", 64'(lat), 64'd33);
    chk("hs2_q", 64'(quotient), 64'd4);
    chk("hs2_r", 64'(remainder), 64'd1);
    @(posedge sys_clk); #1;

    // Reset mid-run.
    dividend = 32'd100; divisor = 32'd7; frac = 1'b0; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    repeat (14) @(posedge sys_clk);
    #1;
    chk("mid_busy_before", 64'(busy), 64'd1);
    resetl = 1'b0;
    @(posedge sys_clk); #1;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_q", 64'(quotient), 64'd0);
    chk("mid_r", 64'(remainder), 64'd0);
    resetl    = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge sys_clk); #1;
      if (done) done_seen = 1'b1;
    end
    chk("mid_no_done", 64'(done_seen), 64'd0);
    run_op(32'd100, 32'd7, 1'b0, lat, bsy);
    chk("post_lat", 64'(lat), 64'd33);
    chk("post_q", 64'(quotient), 64'd14);
    chk("post_r", 64'(remainder), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
